// File: rtl/game_flow_ctrl.sv
// Typing-game sequencer: menu navigation, pre-game countdown, abort/restart.
// Owns the game state, the mode bit and the 7-bit target value consumed by
// the word/time datapath.
module game_flow_ctrl #(
  parameter int unsigned TICK_DIV   = 1000000,
  parameter int unsigned COUNT_SECS = 3,
  parameter int unsigned TIME_MIN   = 15,
  parameter int unsigned TIME_MAX   = 60,
  parameter int unsigned TIME_STEP  = 15,
  parameter int unsigned WORD_MIN   = 10,
  parameter int unsigned WORD_MAX   = 50,
  parameter int unsigned WORD_STEP  = 10
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         key_valid,
  input  logic [8:0]   last_change,
  input  logic [127:0] key_down,
  input  logic         finish,
  output logic [1:0]   state,
  output logic         mode,
  output logic [6:0]   value,
  output logic [3:0]   cd_digit,
  output logic         start_pulse
);

  typedef enum logic [1:0] {
    S_SELECT    = 2'd0,
    S_COUNTDOWN = 2'd1,
    S_INGAME    = 2'd2,
    S_FINISH    = 2'd3
  } state_t;

  localparam int unsigned TICK_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(TICK_DIV - 1);
  localparam logic [6:0] SEC_LAST = 7'd99;

  localparam logic [8:0] KEY_ENTER = 9'h05A;
  localparam logic [8:0] KEY_ESC   = 9'h076;
  localparam logic [8:0] KEY_TAB   = 9'h00D;
  localparam logic [8:0] KEY_UP    = 9'h175;
  localparam logic [8:0] KEY_DOWN  = 9'h172;

  state_t              r_state;
  logic                r_mode;
  logic [6:0]          r_value;
  logic [3:0]          r_cd;
  logic                r_start;
  logic                r_held;
  logic [TICK_W-1:0]   r_tick_cnt;
  logic [6:0]          r_sec_cnt;

  state_t              w_state_nxt;
  logic                w_mode_nxt;
  logic [6:0]          w_value_nxt;
  logic [3:0]          w_cd_nxt;
  logic                w_start_nxt;
  logic [TICK_W-1:0]   w_tick_nxt;
  logic [6:0]          w_sec_nxt;

  logic                w_key_bit;
  logic                w_press;
  logic                w_enter, w_esc, w_tab, w_up, w_down;
  logic [6:0]          w_min, w_max, w_step, w_tab_min;
  logic [7:0]          w_sum;
  logic [6:0]          w_up_val, w_down_val;
  logic                w_tick;

  // Make-event detection: a key counts once per make, auto-repeat suppressed.
  assign w_key_bit = key_down[last_change[6:0]];
  assign w_press   = key_valid & w_key_bit & ~r_held;
  assign w_enter   = w_press & (last_change == KEY_ENTER);
  assign w_esc     = w_press & (last_change == KEY_ESC);
  assign w_tab     = w_press & (last_change == KEY_TAB);
  assign w_up      = w_press & (last_change == KEY_UP);
  assign w_down    = w_press & (last_change == KEY_DOWN);

  // Value range of the current mode, and the minimum of the other mode for TAB.
  assign w_min     = r_mode ? 7'(WORD_MIN)  : 7'(TIME_MIN);
  assign w_max     = r_mode ? 7'(WORD_MAX)  : 7'(TIME_MAX);
  assign w_step    = r_mode ? 7'(WORD_STEP) : 7'(TIME_STEP);
  assign w_tab_min = r_mode ? 7'(TIME_MIN)  : 7'(WORD_MIN);

  // Saturating step arithmetic; the sum is 8 bits wide so it never wraps.
  assign w_sum      = {1'b0, r_value} + {1'b0, w_step};
  assign w_up_val   = (w_sum > {1'b0, w_max}) ? w_max : w_sum[6:0];
  assign w_down_val = ({1'b0, r_value} < ({1'b0, w_min} + {1'b0, w_step}))
                      ? w_min : (r_value - w_step);

  assign w_tick = (r_tick_cnt == TICK_LAST);

  // State and datapath registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= S_SELECT;
      r_mode     <= 1'b0;
      r_value    <= 7'(TIME_MIN);
      r_cd       <= 4'd0;
      r_start    <= 1'b0;
      r_held     <= 1'b0;
      r_tick_cnt <= '0;
      r_sec_cnt  <= 7'd0;
    end else begin
      r_state    <= w_state_nxt;
      r_mode     <= w_mode_nxt;
      r_value    <= w_value_nxt;
      r_cd       <= w_cd_nxt;
      r_start    <= w_start_nxt;
      r_held     <= w_key_bit;
      r_tick_cnt <= w_tick_nxt;
      r_sec_cnt  <= w_sec_nxt;
    end
  end

  // Next-state and next-output decode; counters idle at 0 outside COUNTDOWN.
  always_comb begin
    w_state_nxt = r_state;
    w_mode_nxt  = r_mode;
    w_value_nxt = r_value;
    w_cd_nxt    = r_cd;
    w_start_nxt = 1'b0;
    w_tick_nxt  = '0;
    w_sec_nxt   = 7'd0;
    case (r_state)
      S_SELECT: begin
        if (w_tab) begin
          w_mode_nxt  = ~r_mode;
          w_value_nxt = w_tab_min;
        end else if (w_up) begin
          w_value_nxt = w_up_val;
        end else if (w_down) begin
          w_value_nxt = w_down_val;
        end else if (w_enter) begin
          w_state_nxt = S_COUNTDOWN;
          w_cd_nxt    = 4'(COUNT_SECS);
        end
      end
      S_COUNTDOWN: begin
        if (w_esc) begin
          w_state_nxt = S_SELECT;
          w_cd_nxt    = 4'd0;
        end else begin
          w_tick_nxt = w_tick ? '0 : (r_tick_cnt + TICK_W'(1));
          w_sec_nxt  = r_sec_cnt;
          if (w_tick) begin
            if (r_sec_cnt == SEC_LAST) begin
              w_sec_nxt = 7'd0;
              if (r_cd == 4'd1) begin
                w_state_nxt = S_INGAME;
                w_cd_nxt    = 4'd0;
                w_start_nxt = 1'b1;
                w_tick_nxt  = '0;
              end else begin
                w_cd_nxt = r_cd - 4'd1;
              end
            end else begin
              w_sec_nxt = r_sec_cnt + 7'd1;
            end
          end
        end
      end
      S_INGAME: begin
        if (w_esc) begin
          w_state_nxt = S_SELECT;
        end else if (finish) begin
          w_state_nxt = S_FINISH;
        end
      end
      S_FINISH: begin
        if (w_enter || w_esc) begin
          w_state_nxt = S_SELECT;
        end
      end
      default: begin
        w_state_nxt = S_SELECT;
      end
    endcase
  end

  assign state       = r_state;
  assign mode        = r_mode;
  assign value       = r_value;
  assign cd_digit    = r_cd;
  assign start_pulse = r_start;

endmodule

// File: tb/tb_game_flow_ctrl.sv
// Directed bench for game_flow_ctrl with a short tick divider.
module tb_game_flow_ctrl;

  logic         clk;
  logic         rst;
  logic         key_valid;
  logic [8:0]   last_change;
  logic [127:0] key_down;
  logic         finish;
  logic [1:0]   state;
  logic         mode;
  logic [6:0]   value;
  logic [3:0]   cd_digit;
  logic         start_pulse;

  int n_vec = 0;
  int n_bad = 0;

  localparam logic [8:0] K_ENTER = 9'h05A;
  localparam logic [8:0] K_ESC   = 9'h076;
  localparam logic [8:0] K_TAB   = 9'h00D;
  localparam logic [8:0] K_UP    = 9'h175;
  localparam logic [8:0] K_DOWN  = 9'h172;
  localparam logic [8:0] K_A     = 9'h01C;

  game_flow_ctrl #(
    .TICK_DIV   (4),
    .COUNT_SECS (3),
    .TIME_MIN   (15),
    .TIME_MAX   (60),
    .TIME_STEP  (15),
    .WORD_MIN   (10),
    .WORD_MAX   (50),
    .WORD_STEP  (10)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .key_valid   (key_valid),
    .last_change (last_change),
    .key_down    (key_down),
    .finish      (finish),
    .state       (state),
    .mode        (mode),
    .value       (value),
    .cd_digit    (cd_digit),
    .start_pulse (start_pulse)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // One idle cycle with all keys up, then a single-cycle make event.
  task automatic press(input logic [8:0] code);
    key_valid = 1'b0;
    key_down  = '0;
    @(posedge clk); #1;
    last_change = code;
    key_down    = '0;
    key_down[code[6:0]] = 1'b1;
    key_valid   = 1'b1;
    @(posedge clk); #1;
    key_valid = 1'b0;
    key_down  = '0;
  endtask

  initial begin
    rst = 1'b1; key_valid = 1'b0; last_change = '0; key_down = '0; finish = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    check("rst_state", 32'(state), 32'd0);
    check("rst_mode", 32'(mode), 32'd0);
    check("rst_value", 32'(value), 32'd15);
    check("rst_cd", 32'(cd_digit), 32'd0);
    check("rst_start", 32'(start_pulse), 32'd0);
    rst = 1'b0;

    // Menu navigation in word mode with saturation at the top.
    press(K_TAB);
    check("tab_mode", 32'(mode), 32'd1);
    check("tab_value", 32'(value), 32'd10);
    press(K_UP); check("up1", 32'(value), 32'd20);
    press(K_UP); check("up2", 32'(value), 32'd30);
    press(K_UP); check("up3", 32'(value), 32'd40);
    press(K_UP); check("up4", 32'(value), 32'd50);
    press(K_UP); check("up5_sat", 32'(value), 32'd50);
    press(K_DOWN); check("down1", 32'(value), 32'd40);
    check("sel_state", 32'(state), 32'd0);
    press(K_A);
    check("other_key_value", 32'(value), 32'd40);
    press(K_ESC);
    check("esc_sel_state", 32'(state), 32'd0);
    check("esc_sel_value", 32'(value), 32'd40);

    // Held key with repeated strobes yields a single step.
    press(K_TAB);
    check("tab2_mode", 32'(mode), 32'd0);
    check("tab2_value", 32'(value), 32'd15);
    @(posedge clk); #1;
    last_change = K_UP; key_down = '0; key_down[7'h75] = 1'b1; key_valid = 1'b1;
    @(posedge clk); #1;
    check("hold_first", 32'(value), 32'd30);
    repeat (4) begin @(posedge clk); #1; end
    check("hold_repeat", 32'(value), 32'd30);
    key_down = '0;
    @(posedge clk); #1;
    key_valid = 1'b0;
    check("release_value", 32'(value), 32'd30);
    press(K_DOWN); check("down_sat_min", 32'(value), 32'd15);
    press(K_TAB); check("tab3_value", 32'(value), 32'd10);
    press(K_UP); press(K_UP); press(K_UP);
    check("word40", 32'(value), 32'd40);

    // Full countdown: 400 cycles per digit, INGAME 1200 edges after the press.
    press(K_ENTER);
    check("cd_enter_state", 32'(state), 32'd1);
    check("cd_enter_digit", 32'(cd_digit), 32'd3);
    for (int i = 1; i <= 1201; i++) begin
      @(posedge clk); #1;
      if (i == 399)  check("cd3_end", 32'(cd_digit), 32'd3);
      if (i == 400)  check("cd2_start", 32'(cd_digit), 32'd2);
      if (i == 799)  check("cd2_end", 32'(cd_digit), 32'd2);
      if (i == 800)  check("cd1_start", 32'(cd_digit), 32'd1);
      if (i == 1199) begin
        check("cd1_end_state", 32'(state), 32'd1);
        check("cd1_end_pulse", 32'(start_pulse), 32'd0);
      end
      if (i == 1200) begin
        check("ingame_state", 32'(state), 32'd2);
        check("ingame_pulse", 32'(start_pulse), 32'd1);
        check("ingame_cd", 32'(cd_digit), 32'd0);
      end
      if (i == 1201) begin
        check("pulse_single", 32'(start_pulse), 32'd0);
        check("ingame_hold", 32'(state), 32'd2);
      end
    end

    // finish -> FINISH, then ENTER back to SELECT keeping the settings.
    finish = 1'b1;
    @(posedge clk); #1;
    finish = 1'b0;
    check("finish_state", 32'(state), 32'd3);
    press(K_ENTER);
    check("replay_state", 32'(state), 32'd0);
    check("replay_mode", 32'(mode), 32'd1);
    check("replay_value", 32'(value), 32'd40);

    // ESC mid-countdown, then a restart with a full first second.
    press(K_ENTER);
    for (int i = 1; i <= 400; i++) begin
      @(posedge clk); #1;
    end
    check("abort_pre_cd", 32'(cd_digit), 32'd2);
    press(K_ESC);
    check("abort_state", 32'(state), 32'd0);
    check("abort_cd", 32'(cd_digit), 32'd0);
    press(K_ENTER);
    check("restart_cd", 32'(cd_digit), 32'd3);
    for (int i = 1; i <= 400; i++) begin
      @(posedge clk); #1;
      if (i == 399) check("restart_cd3_end", 32'(cd_digit), 32'd3);
      if (i == 400) check("restart_cd2", 32'(cd_digit), 32'd2);
    end
    check("restart_frozen_value", 32'(value), 32'd40);
    press(K_ESC);
    check("abort2_state", 32'(state), 32'd0);

    // Asynchronous reset in the middle of a countdown.
    press(K_ENTER);
    for (int i = 1; i <= 100; i++) begin
      @(posedge clk); #1;
    end
    #3 rst = 1'b1;
    #1;
    check("arst_state", 32'(state), 32'd0);
    check("arst_mode", 32'(mode), 32'd0);
    check("arst_value", 32'(value), 32'd15);
    check("arst_cd", 32'(cd_digit), 32'd0);
    check("arst_pulse", 32'(start_pulse), 32'd0);
    #2 rst = 1'b0;

    // finish and ESC in the same INGAME cycle: ESC wins.
    press(K_ENTER);
    for (int i = 1; i <= 1200; i++) begin
      @(posedge clk); #1;
    end
    check("ingame2_state", 32'(state), 32'd2);
    finish = 1'b1;
    last_change = K_ESC; key_down = '0; key_down[7'h76] = 1'b1; key_valid = 1'b1;
    @(posedge clk); #1;
    key_valid = 1'b0; key_down = '0;
    check("esc_beats_finish", 32'(state), 32'd0);
    @(posedge clk); #1;
    check("finish_in_select", 32'(state), 32'd0);
    finish = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
